wb_regfile_hilo: RTL and testbench
==================================

WB_REGFILE_HILO -- requirements
Module: wb_regfile_hilo

Interface
REQ-001 Parameter DATA_W, default 32, width of every GPR, HI, LO and data port.
REQ-002 Parameter ADDR_W, default 5, GPR address width; register count = 2**ADDR_W (32).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 we  input  1  GPR write enable from writeback stage (wb_wreg).
REQ-006 waddr  input  ADDR_W  GPR write address (wb_wd).
REQ-007 wdata  input  DATA_W  GPR write data (wb_wdata).
REQ-008 re1  input  1  read port 1 enable from decode.
REQ-009 raddr1  input  ADDR_W  read port 1 address.
REQ-010 rdata1  output  DATA_W  read port 1 data, combinational.
REQ-011 re2  input  1  read port 2 enable.
REQ-012 raddr2  input  ADDR_W  read port 2 address.
REQ-013 rdata2  output  DATA_W  read port 2 data, combinational.
REQ-014 whilo  input  1  HI/LO write enable (wb_whilo).
REQ-015 hi_i  input  DATA_W  HI write data (wb_hi).
REQ-016 lo_i  input  DATA_W  LO write data (wb_lo).
REQ-017 hi_o  output  DATA_W  current HI register value, registered.
REQ-018 lo_o  output  DATA_W  current LO register value, registered.

Function
REQ-019 The block SHALL hold 32 GPRs of DATA_W bits and one HI and one LO register of DATA_W bits each.
REQ-020 On a rising edge with rst=0, we=1 and waddr!=0, GPR[waddr] SHALL take wdata; writes to address 0 SHALL be discarded.
REQ-021 GPR[0] SHALL always read as 0, regardless of any write.
REQ-022 On a rising edge with rst=0 and whilo=1, HI SHALL take hi_i and LO SHALL take lo_i in the same cycle; whilo=0 SHALL leave both unchanged.
REQ-023 hi_o/lo_o SHALL reflect HI/LO registers directly, with no bypass; new values are visible one cycle after the write edge (EX-stage forwarding is handled upstream).
REQ-024 Read port n priority, highest first: rst=1 -> 0; raddr_n=0 -> 0; re_n=1, we=1 and raddr_n=waddr -> wdata (same-cycle write bypass); re_n=1 -> GPR[raddr_n]; re_n=0 -> 0.
REQ-025 Both read ports SHALL operate independently and may address the same register, each honouring REQ-024.
REQ-026 A write and a bypassed read of the same address in one cycle SHALL return wdata combinationally and store wdata at the edge.
REQ-027 Read latency SHALL be zero cycles (combinational); write latency one edge.

Reset
REQ-028 While rst=1 at a rising edge, all 32 GPRs, HI and LO SHALL be cleared to 0 and we/whilo SHALL be ignored.
REQ-029 While rst=1, rdata1 and rdata2 SHALL be 0 combinationally; hi_o/lo_o SHALL be 0 from the first reset edge.
REQ-030 A write asserted in the same cycle rst is asserted SHALL be lost; first write takes effect on the first edge with rst=0.

Verification
REQ-031 Reset then we=1,waddr=3,wdata=0x12345678; next cycle re1=1,raddr1=3 -> rdata1=0x12345678.
REQ-032 we=1,waddr=0,wdata=0xFFFFFFFF; later re1=1,raddr1=0 -> rdata1=0 (also 0 during the write cycle).
REQ-033 Same cycle we=1,waddr=7,wdata=0xA5A5A5A5, re2=1,raddr2=7 (GPR7 previously 0x1) -> rdata2=0xA5A5A5A5 that cycle and thereafter.
REQ-034 whilo=1,hi_i=0x00000002,lo_i=0xFFFFFFFE -> hi_o/lo_o unchanged before edge, 0x00000002/0xFFFFFFFE after; next cycle whilo=0,hi_i=0x5 -> hi_o stays 0x00000002.
REQ-035 GPR5=0xDEAD0000, HI=0x1; assert rst one cycle with we=1,waddr=5,wdata=0x1 -> after edge GPR5=0, hi_o=0, rdata1=0 while rst=1; re1=0,raddr1=5 after reset -> rdata1=0.

Source files
------------

// File: rtl/wb_regfile_hilo.sv
// Writeback-stage register file: 32 GPRs with two combinational read ports
// (same-cycle write bypass) plus the HI/LO multiply/divide result pair.
module wb_regfile_hilo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr [NUM_REGS];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // NOTE: the whole array is cleared on reset because software relies on
    // zeroed GPRs; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            gpr[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (whilo) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

    // Register 0 is hardwired; a pending write to the read address is forwarded.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_v,
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic              we_v,
        input logic [ADDR_W-1:0] waddr_v,
        input logic [DATA_W-1:0] wdata_v,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] result;
        result = '0;
        if (rst_v || (raddr == '0) || !re) begin
            result = '0;
        end else if (we_v && (raddr == waddr_v)) begin
            result = wdata_v;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    // NOTE: each output gets its default before any branch so no latch forms.
    always_comb begin
        rdata1 = '0;
        rdata1 = read_port(rst, re1, raddr1, we, waddr, wdata, gpr[raddr1]);
    end

    always_comb begin
        rdata2 = '0;
        rdata2 = read_port(rst, re2, raddr2, we, waddr, wdata, gpr[raddr2]);
    end

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Self-checking bench for wb_regfile_hilo: directed scenarios with literal
// expectations, then randomized traffic compared against an array model.
module tb_wb_regfile_hilo;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              whilo;
    logic [DATA_W-1:0] hi_i;
    logic [DATA_W-1:0] lo_i;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Architectural model: plain arrays updated by the stated rules.
    logic [DATA_W-1:0] m_gpr [32];
    logic [DATA_W-1:0] m_hi;
    logic [DATA_W-1:0] m_lo;

    wb_regfile_hilo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic r, input logic [ADDR_W-1:0] a);
        if (rst)               return '0;
        if (a == 0)            return '0;
        if (!r)                return '0;
        if (we && a == waddr)  return wdata;
        return m_gpr[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = '0;
            m_hi = '0;
            m_lo = '0;
        end else begin
            if (we && waddr != 0) m_gpr[waddr] = wdata;
            if (whilo) begin
                m_hi = hi_i;
                m_lo = lo_i;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_rdata1", rdata1, model_read(re1, raddr1));
            check("model_rdata2", rdata2, model_read(re2, raddr2));
            check("model_hi_o", hi_o, m_hi);
            check("model_lo_o", lo_o, m_lo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        we = 0; waddr = '0; wdata = '0;
        re1 = 0; raddr1 = '0; re2 = 0; raddr2 = '0;
        whilo = 0; hi_i = '0; lo_i = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        we = 1; waddr = 5'd3; wdata = 32'hCAFE_F00D;
        re1 = 1; raddr1 = 5'd3; re2 = 1; raddr2 = 5'd3;
        step();
        cmp_en = 1'b1;
        settle();
        check("reset_rdata1", rdata1, 32'h0);
        check("reset_rdata2", rdata2, 32'h0);
        check("reset_hi_o", hi_o, 32'h0);
        check("reset_lo_o", lo_o, 32'h0);
        step();

        // Write GPR3 then read it back the next cycle.
        rst = 0;
        idle_inputs();
        we = 1; waddr = 5'd3; wdata = 32'h1234_5678;
        step();
        idle_inputs();
        re1 = 1; raddr1 = 5'd3;
        settle();
        check("gpr3_readback", rdata1, 32'h1234_5678);

        // Writes to register 0 are discarded and it always reads zero.
        we = 1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; re1 = 1; raddr1 = 5'd0;
        settle();
        check("r0_during_write", rdata1, 32'h0);
        step();
        we = 0;
        settle();
        check("r0_after_write", rdata1, 32'h0);

        // Same-cycle bypass on port 2.
        idle_inputs();
        we = 1; waddr = 5'd7; wdata = 32'h0000_0001;
        step();
        we = 1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; re2 = 1; raddr2 = 5'd7;
        settle();
        check("bypass_same_cycle", rdata2, 32'hA5A5_A5A5);
        step();
        we = 0;
        settle();
        check("bypass_stored", rdata2, 32'hA5A5_A5A5);

        // HI/LO write visible only after the edge, held when whilo=0.
        idle_inputs();
        whilo = 1; hi_i = 32'h0000_0002; lo_i = 32'hFFFF_FFFE;
        settle();
        check("hi_before_edge", hi_o, 32'h0);
        check("lo_before_edge", lo_o, 32'h0);
        step();
        whilo = 0; hi_i = 32'h5; lo_i = 32'h6;
        settle();
        check("hi_after_edge", hi_o, 32'h0000_0002);
        check("lo_after_edge", lo_o, 32'hFFFF_FFFE);
        step();
        check("hi_held", hi_o, 32'h0000_0002);

        // Reset clears GPRs and HI/LO, and a concurrent write is lost.
        idle_inputs();
        we = 1; waddr = 5'd5; wdata = 32'hDEAD_0000;
        whilo = 1; hi_i = 32'h1; lo_i = 32'h0;
        step();
        idle_inputs();
        re1 = 1; raddr1 = 5'd5;
        settle();
        check("gpr5_loaded", rdata1, 32'hDEAD_0000);
        check("hi_loaded", hi_o, 32'h1);
        rst = 1; we = 1; waddr = 5'd5; wdata = 32'h1;
        settle();
        check("rdata1_in_reset", rdata1, 32'h0);
        step();
        check("hi_cleared", hi_o, 32'h0);
        rst = 0; idle_inputs(); raddr1 = 5'd5;
        settle();
        check("re1_low_reads_zero", rdata1, 32'h0);
        re1 = 1;
        settle();
        check("gpr5_cleared", rdata1, 32'h0);

        // Randomized traffic, narrow address range to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst    = ($urandom_range(0, 63) == 0);
            we     = $urandom_range(0, 1);
            waddr  = ADDR_W'($urandom_range(0, (c < 1500) ? 7 : 31));
            wdata  = $urandom;
            re1    = ($urandom_range(0, 3) != 0);
            raddr1 = ADDR_W'($urandom_range(0, (c < 1500) ? 7 : 31));
            re2    = ($urandom_range(0, 3) != 0);
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : ADDR_W'($urandom_range(0, 31));
            whilo  = $urandom_range(0, 1);
            hi_i   = $urandom;
            lo_i   = $urandom;
        end
        step();
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
